// File: rtl/datapath_controller.sv
// rtl/datapath_controller.sv - multicycle fetch/decode/execute controller for the 16-bit datapath
module datapath_controller #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [PC_W-1:0] mem_addr,
    output logic [15:0]     mem_wdata,
    input  logic            mem_ack,
    input  logic [15:0]     mem_rdata,
    output logic [15:0]     instruction,
    input  logic [15:0]     srcData,
    input  logic [15:0]     dstData,
    input  logic            C,
    input  logic            L,
    input  logic            F,
    input  logic            Z,
    input  logic            N,
    output logic [3:0]      aluControl,
    output logic            srcRegEn,
    output logic            dstRegEn,
    output logic            immRegEn,
    output logic            irS,
    output logic            signEn,
    output logic            regFileEn,
    output logic            shiftALUMuxEn,
    output logic            regImmMuxEn,
    output logic            pcRegEn,
    output logic            pcRegMuxEn,
    output logic [1:0]      mux4En,
    output logic [1:0]      exMemResultEn,
    output logic [PC_W-1:0] pc,
    output logic [4:0]      psr
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t          state;
    logic [PC_W-1:0] ipc;

    logic [3:0] op, rdest, ext, code;
    logic       is_alu, is_shift, is_bcond, is_jcond, is_load, is_stor, is_mem;
    logic       sets_flags, cond_true, br_taken, j_taken;
    logic [PC_W-1:0] br_target;

    assign op    = instruction[15:12];
    assign rdest = instruction[11:8];
    assign ext   = instruction[7:4];

    // R-type ops carry their ALU code in ext; immediate ops carry it in op.
    assign code       = (op == 4'h0) ? ext : op;
    assign is_alu     = code inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    assign sets_flags = is_alu && (code inside {4'h5, 4'h9, 4'hB});
    assign is_shift   = (op == 4'h8) && (ext inside {4'h0, 4'h1, 4'h4});
    assign is_bcond   = (op == 4'hC);
    assign is_jcond   = (op == 4'h4) && (ext == 4'hC);
    assign is_load    = (op == 4'h4) && (ext == 4'h0);
    assign is_stor    = (op == 4'h4) && (ext == 4'h4);
    assign is_mem     = is_load || is_stor;

    // psr layout is {C,L,F,Z,N}
    always_comb begin
        cond_true = 1'b0;
        case (rdest)
            4'h0:    cond_true = psr[1];
            4'h1:    cond_true = !psr[1];
            4'h2:    cond_true = psr[4];
            4'h3:    cond_true = !psr[4];
            4'h6:    cond_true = psr[0];
            4'h7:    cond_true = !psr[0];
            4'h8:    cond_true = psr[2];
            4'h9:    cond_true = !psr[2];
            4'hA:    cond_true = psr[3];
            4'hB:    cond_true = !psr[3];
            4'hE:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign br_taken  = is_bcond && cond_true;
    assign j_taken   = is_jcond && cond_true;
    assign br_target = ipc + {{(PC_W-8){instruction[7]}}, instruction[7:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            ipc         <= RESET_PC;
            psr         <= 5'b0;
            instruction <= 16'h0000;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        instruction <= mem_rdata;
                        ipc         <= pc;
                        pc          <= pc + {{(PC_W-1){1'b0}}, 1'b1};
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: state <= is_mem ? S_MEM : S_EXEC;
                S_EXEC: begin
                    if (sets_flags)
                        psr <= {C, L, F, Z, N};
                    if (br_taken)
                        pc <= br_target;
                    else if (j_taken)
                        pc <= srcData[PC_W-1:0];
                    state <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ack)
                        state <= is_load ? S_WB : S_FETCH;
                end
                S_WB:    state <= S_FETCH;
                default: state <= S_FETCH;
            endcase
        end
    end

    // The register file is not written during MEM, so srcData/dstData hold steady until ack.
    assign mem_req   = reset && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we    = reset && (state == S_MEM) && is_stor;
    assign mem_addr  = (state == S_MEM) ? srcData[PC_W-1:0] : pc;
    assign mem_wdata = dstData;

    always_comb begin
        aluControl    = 4'h0;
        srcRegEn      = 1'b0;
        dstRegEn      = 1'b0;
        immRegEn      = 1'b0;
        irS           = 1'b0;
        signEn        = 1'b0;
        regFileEn     = 1'b0;
        shiftALUMuxEn = 1'b0;
        regImmMuxEn   = 1'b0;
        pcRegEn       = 1'b0;
        pcRegMuxEn    = 1'b0;
        mux4En        = 2'b00;
        exMemResultEn = 2'b00;
        case (state)
            S_DECODE: begin
                irS      = 1'b1;
                srcRegEn = 1'b1;
                dstRegEn = 1'b1;
                immRegEn = 1'b1;
            end
            S_EXEC: begin
                if (is_alu) begin
                    mux4En        = (op == 4'h0) ? 2'b00 : 2'b01;
                    aluControl    = code;
                    signEn        = !(op inside {4'h1, 4'h2, 4'h3});
                    regFileEn     = (code != 4'hB);
                    exMemResultEn = (code == 4'hD) ? 2'b10 : 2'b00;
                end else if (is_shift) begin
                    shiftALUMuxEn = 1'b1;
                    regFileEn     = 1'b1;
                    regImmMuxEn   = (ext != 4'h4);
                    signEn        = (ext != 4'h4);
                end else if (br_taken || j_taken) begin
                    pcRegEn    = 1'b1;
                    pcRegMuxEn = j_taken;
                end
            end
            S_WB: begin
                exMemResultEn = 2'b01;
                regFileEn     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// tb/tb_datapath_controller.sv - directed-vector bench for datapath_controller
module tb_datapath_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, instruction;
    logic [15:0] srcData, dstData;
    logic        C, L, F, Z, N;
    logic [3:0]  aluControl;
    logic        srcRegEn, dstRegEn, immRegEn, irS, signEn, regFileEn;
    logic        shiftALUMuxEn, regImmMuxEn, pcRegEn, pcRegMuxEn;
    logic [1:0]  mux4En, exMemResultEn;
    logic [15:0] pc;
    logic [4:0]  psr;

    int total = 0;
    int bad   = 0;

    datapath_controller dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(instruction),
        .srcData(srcData), .dstData(dstData),
        .C(C), .L(L), .F(F), .Z(Z), .N(N),
        .aluControl(aluControl), .srcRegEn(srcRegEn), .dstRegEn(dstRegEn),
        .immRegEn(immRegEn), .irS(irS), .signEn(signEn), .regFileEn(regFileEn),
        .shiftALUMuxEn(shiftALUMuxEn), .regImmMuxEn(regImmMuxEn),
        .pcRegEn(pcRegEn), .pcRegMuxEn(pcRegMuxEn),
        .mux4En(mux4En), .exMemResultEn(exMemResultEn),
        .pc(pc), .psr(psr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [4:0] f);
        {C, L, F, Z, N} = f;
    endtask

    // Must be called while in FETCH; leaves the FSM in DECODE.
    task automatic fetch(input logic [15:0] ins, input logic [15:0] addr);
        chk("fetch_req", 32'(mem_req), 32'd1);
        chk("fetch_addr", 32'(mem_addr), 32'(addr));
        mem_rdata = ins;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        chk("decode_irs", 32'(irS), 32'd1);
        chk("decode_instr", 32'(instruction), 32'(ins));
    endtask

    initial begin
        reset = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
        srcData = 16'h0; dstData = 16'h0;
        set_flags(5'b0);
        tick(); tick();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_psr", 32'(psr), 32'h0);
        chk("rst_instr", 32'(instruction), 32'h0);
        reset = 1'b1;
        tick();

        // ADD R2,R3
        set_flags(5'b10010);
        fetch(16'h0253, 16'h0000);
        chk("add_dec_rf", 32'(regFileEn), 32'd0);
        chk("add_dec_pc", 32'(pc), 32'h0001);
        tick();
        chk("add_alu", 32'(aluControl), 32'h5);
        chk("add_mux4", 32'(mux4En), 32'h0);
        chk("add_rf", 32'(regFileEn), 32'd1);
        chk("add_exm", 32'(exMemResultEn), 32'h0);
        tick();
        chk("add_rf_off", 32'(regFileEn), 32'd0);
        chk("add_psr", 32'(psr), 32'h12);

        // ANDI imm 0x80 zero-extends and leaves psr alone
        set_flags(5'b11111);
        fetch(16'h1380, 16'h0001);
        tick();
        chk("andi_sign", 32'(signEn), 32'd0);
        chk("andi_mux4", 32'(mux4En), 32'h1);
        chk("andi_alu", 32'(aluControl), 32'h1);
        tick();
        chk("andi_psr", 32'(psr), 32'h12);

        // ADDI imm 0x80 sign-extends and latches flags
        set_flags(5'b01101);
        fetch(16'h5380, 16'h0002);
        tick();
        chk("addi_sign", 32'(signEn), 32'd1);
        chk("addi_alu", 32'(aluControl), 32'h5);
        tick();
        chk("addi_psr", 32'(psr), 32'h0D);

        // LOAD with three wait cycles
        srcData = 16'h0040;
        fetch(16'h4102, 16'h0003);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ld_req", 32'(mem_req), 32'd1);
            chk("ld_we", 32'(mem_we), 32'd0);
            chk("ld_addr", 32'(mem_addr), 32'h0040);
            tick();
        end
        chk("ld_addr_ack", 32'(mem_addr), 32'h0040);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0;
        chk("wb_exm", 32'(exMemResultEn), 32'h1);
        chk("wb_rf", 32'(regFileEn), 32'd1);
        chk("wb_req", 32'(mem_req), 32'd0);
        tick();
        chk("ld_next_req", 32'(mem_req), 32'd1);
        chk("ld_next_addr", 32'(mem_addr), 32'h0004);

        // STOR with zero-wait ack
        srcData = 16'h0041; dstData = 16'hBEEF;
        fetch(16'h4142, 16'h0004);
        tick();
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_addr", 32'(mem_addr), 32'h0041);
        chk("st_wdata", 32'(mem_wdata), 32'hBEEF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;

        // JUC to 0x000F, CMPI with Z=1, BEQ -2 at 0x0010 is taken
        srcData = 16'h000F;
        fetch(16'h4EC2, 16'h0005);
        tick();
        chk("j_pcen", 32'(pcRegEn), 32'd1);
        chk("j_pcmux", 32'(pcRegMuxEn), 32'd1);
        tick();
        set_flags(5'b00010);
        fetch(16'hB105, 16'h000F);
        tick();
        chk("cmpi_rf", 32'(regFileEn), 32'd0);
        chk("cmpi_alu", 32'(aluControl), 32'hB);
        tick();
        chk("cmpi_psr", 32'(psr), 32'h02);
        set_flags(5'b0);
        fetch(16'hC0FE, 16'h0010);
        tick();
        chk("beq_pcen", 32'(pcRegEn), 32'd1);
        chk("beq_pcmux", 32'(pcRegMuxEn), 32'd0);
        tick();
        chk("beq_taken_pc", 32'(pc), 32'h000E);

        // Same with Z=0: not taken
        fetch(16'h4EC2, 16'h000E);
        tick(); tick();
        set_flags(5'b00000);
        fetch(16'hB105, 16'h000F);
        tick(); tick();
        chk("cmpi0_psr", 32'(psr), 32'h00);
        fetch(16'hC0FE, 16'h0010);
        tick();
        chk("bne_pcen", 32'(pcRegEn), 32'd0);
        tick();
        chk("beq_fall_pc", 32'(pc), 32'h0011);

        // JUC to FFFF, then the PC wraps on the following fetch (unknown op = NOP)
        srcData = 16'hFFFF;
        fetch(16'h4EC2, 16'h0011);
        tick(); tick();
        chk("j_ffff_pc", 32'(pc), 32'hFFFF);
        fetch(16'hF000, 16'hFFFF);
        chk("wrap_pc", 32'(pc), 32'h0000);
        tick();
        chk("nop_rf", 32'(regFileEn), 32'd0);
        chk("nop_pcen", 32'(pcRegEn), 32'd0);
        tick();

        // LSHI
        fetch(16'h8103, 16'h0000);
        tick();
        chk("lshi_shm", 32'(shiftALUMuxEn), 32'd1);
        chk("lshi_rim", 32'(regImmMuxEn), 32'd1);
        chk("lshi_rf", 32'(regFileEn), 32'd1);
        tick();

        // Load psr with a nonzero value, then reset in the middle of a LOAD
        set_flags(5'b11111);
        fetch(16'h5380, 16'h0001);
        tick(); tick();
        chk("pre_rst_psr", 32'(psr), 32'h1F);
        srcData = 16'h0040;
        fetch(16'h4102, 16'h0002);
        tick();
        chk("mem_req_pre", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midmem_req", 32'(mem_req), 32'd0);
        chk("midmem_pc", 32'(pc), 32'h0000);
        chk("midmem_psr", 32'(psr), 32'h00);
        #3 reset = 1'b1;
        tick();
        chk("post_rst_req", 32'(mem_req), 32'd1);
        chk("post_rst_addr", 32'(mem_addr), 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
- Multicycle control FSM that sequences the 16-bit register/ALU/shifter datapath.
- Fetches instructions from memory through a req/ack handshake and latches them.
- Drives the datapath enables and mux selects, owns the PC and the flag register (PSR), and performs loads, stores, branches and jumps.
- Sits between the memory arbiter and the datapath, one instance per CPU.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_W, 16, PC/address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1=store, 0=read; valid while mem_req.
- mem_addr  out  16  memory address; stable while mem_req.
- mem_wdata  out  16  store data (= dstData).
- mem_ack  in  1  request completes at the rising edge where mem_req&mem_ack.
- mem_rdata  in  16  read data, valid with mem_ack.
- instruction  out  16  latched instruction to the datapath.
- srcData, dstData  in  16 each  datapath register read ports.
- C, L, F, Z, N  in  1 each  ALU flag outputs.
- aluControl  out  4  ALU operation.
- srcRegEn, dstRegEn, immRegEn, irS, signEn, regFileEn, shiftALUMuxEn, regImmMuxEn, pcRegEn, pcRegMuxEn  out  1 each  datapath enables/selects.
- mux4En, exMemResultEn  out  2 each  datapath mux selects.
- pc  out  16  current PC.
- psr  out  5  latched {C,L,F,Z,N}.

Behaviour:
- Instruction fields: [15:12] op, [11:8] Rdest, [7:4] ext/imm-hi, [3:0] Rsrc/imm-lo.
- Reset (async, any state): state=FETCH, pc=RESET_PC, psr=0, instruction=16'h0000. All outputs deasserted and all selects 0; mem_req drops immediately.
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack: instruction<=mem_rdata, ipc<=pc, pc<=pc+1, go DECODE.
  - DECODE (1 cycle): irS=1, srcRegEn=dstRegEn=immRegEn=1.
    - op 0100 ext 0000 or 0100 → MEM.
    - Every other op → EXEC, including unknown op/ext.
  - EXEC (1 cycle): execute per the class rules below, then → FETCH.
  - MEM: mem_req=1, mem_addr=srcData.
    - LOAD (ext 0000): mem_we=0; on ack latch mem_rdata, → WB.
    - STOR (ext 0100): mem_we=1, mem_wdata=dstData; on ack → FETCH.
    - mem_addr/we/wdata are held constant until ack; waiting is unbounded.
  - WB (1 cycle): exMemResultEn=01, regFileEn=1, → FETCH.
- EXEC by class:
  - R-type (op 0000): mux4En=00; aluControl=ext.
  - Immediate (op 0001,0010,0011,0101,1001,1011,1101): mux4En=01; aluControl=op.
  - signEn=1 except ANDI/ORI/XORI (op 0001/0010/0011), which zero-extend.
  - Register write: regFileEn=1, exMemResultEn=00, except CMP/CMPI (code 1011), which do not write.
  - MOV/MOVI (code 1101): exMemResultEn=10.
  - Flags: psr<={C,L,F,Z,N} at the EXEC edge only for codes 0101, 1001, 1011. Logic ops and moves leave psr unchanged.
  - Shift (op 1000): shiftALUMuxEn=1, regFileEn=1.
    - ext 0100 (LSH): regImmMuxEn=0, shift amount from register.
    - ext 0000/0001 (LSHI): regImmMuxEn=1, signEn=1, shift amount from immediate.
  - Bcond (op 1100, cond=Rdest field): if cond true, pc<=ipc+sext(imm8), 16-bit wrap.
  - Jcond (op 0100 ext 1100, cond=Rdest field): if cond true, pc<=srcData.
  - Unknown op/ext: no writes, i.e. a NOP.
- Conditions are evaluated on psr, not live flags:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0110 GT: N. 0111 LE: !N.
  - 1000 FS: F. 1001 FC: !F.
  - 1010 LO: L. 1011 HS: !L.
  - 1110 UC: always.
  - All other codes: never.
- Latency with zero-wait ack:
  - 3 cycles: ALU, shift, branch, jump, STOR, NOP.
  - 4 cycles: LOAD.
- PC increment and branch targets wrap modulo 2^16 (pc=FFFF fetch → pc=0000).

Test Plan:
1. Reset low mid-MEM with mem_req=1 → mem_req=0 the same cycle, pc=0000, psr=0. After release, the first FETCH has mem_addr=0000.
2. Fetch ADD R2,R3 (16'h0253), ack on the first cycle → DECODE then EXEC with aluControl=0101, mux4En=00, regFileEn=1 for exactly one cycle; psr latched; next FETCH at pc=0001; 3 cycles total.
3. LOAD with srcData=0x0040, ack delayed 3 cycles → mem_addr=0x0040 and mem_we=0 held stable throughout; WB has exMemResultEn=01, regFileEn=1; one cycle later, FETCH.
4. CMPI with psr Z=1, then BEQ disp=0xFE at ipc=0x0010 → pc=0x000E. Same with Z=0 → pc=0x0011.
5. ANDI imm=0x80 → signEn=0, psr unchanged. ADDI imm=0x80 → signEn=1.
6. Jcond UC with srcData=0xFFFF → pc=FFFF; the next fetch wraps the PC to 0000.
